// File: rtl/pwm_duty_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_duty_scheduler
//
// Purpose
//   Generates the PWM waveform from divider ticks and sequences duty-cycle
//   changes requested by the user-input logic. A period counter advances on
//   each Tick_in and runs 0..PERIOD-1. Increment/decrement requests arrive on
//   a level req / pulse ack handshake. An accepted change is held until the
//   next period boundary, so the duty never changes in the middle of a period
//   and no output pulse is cut short.
//
// Ports
//   Clock_in      in   1      system clock
//   Reset_n       in   1      asynchronous, active-low reset
//   Tick_in       in   1      one-cycle strobe from the divider; advances the counter
//   Inc_req       in   1      level request: raise duty by STEP, held until Req_ack
//   Dec_req       in   1      level request: lower duty by STEP, held until Req_ack
//   Req_ack       out  1      one-cycle pulse: request applied or cancelled
//   Busy          out  1      high from request latch until both requests drop
//   Period_start  out  1      one-cycle pulse in the cycle after the counter wraps
//   Duty_out      out  CNT_W  currently applied duty, in ticks
//   PWM_out       out  1      registered PWM output, high while cnt < Duty_out
// -----------------------------------------------------------------------------
module pwm_duty_scheduler #(
  parameter int CNT_W    = 8,    // 2**CNT_W must exceed PERIOD
  parameter int PERIOD   = 200,  // ticks per PWM period, >= 2
  parameter int STEP     = 10,   // duty change per accepted request, 1..PERIOD
  parameter int DUTY_RST = 100   // duty after reset, 0..PERIOD
) (
  input  logic             Clock_in,
  input  logic             Reset_n,
  input  logic             Tick_in,
  input  logic             Inc_req,
  input  logic             Dec_req,
  output logic             Req_ack,
  output logic             Busy,
  output logic             Period_start,
  output logic [CNT_W-1:0] Duty_out,
  output logic             PWM_out
);

  // Constants at working widths. Duty arithmetic runs one bit wider than the
  // registers so duty + STEP cannot overflow before it is clamped to PERIOD.
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RST);
  localparam logic [CNT_W:0]   PERIOD_X  = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X    = (CNT_W + 1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // waiting for a request
    S_PENDING = 2'd1,  // direction latched, waiting for the period boundary
    S_ACK     = 2'd2,  // one-cycle acknowledge
    S_RELEASE = 2'd3   // waiting for the requester to drop its lines
  } state_e;

  state_e           state_q, state_d;
  logic             dir_up_q, dir_up_d;  // 1: increment, 0: decrement
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q;
  logic             period_start_q;

  logic             wrap;
  logic             apply;
  logic [CNT_W:0]   duty_x;
  logic [CNT_W:0]   inc_sum;
  logic [CNT_W:0]   inc_val;
  logic [CNT_W:0]   dec_val;
  logic [CNT_W:0]   new_duty;

  // Last tick of the period: the counter returns to 0 on this edge.
  assign wrap = Tick_in && (cnt_q == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Control FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    apply    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Inc_req && Dec_req) begin
          // Opposing requests cancel: acknowledge without touching the duty.
          state_d = S_ACK;
        end else if (Inc_req || Dec_req) begin
          dir_up_d = Inc_req;
          state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        // Request lines are ignored here; only the period boundary matters.
        // A wrap in the latch cycle itself is seen in S_IDLE and not used,
        // so that case waits for the following wrap.
        if (wrap) begin
          apply   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Requests still held after the ack are not serviced a second time.
        if (!Inc_req && !Dec_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Duty arithmetic (saturating at 0 and PERIOD)
  // ---------------------------------------------------------------------------
  always_comb begin
    duty_x   = {1'b0, duty_q};
    inc_sum  = duty_x + STEP_X;
    inc_val  = (inc_sum > PERIOD_X) ? PERIOD_X : inc_sum;
    dec_val  = (duty_x < STEP_X) ? '0 : (duty_x - STEP_X);
    new_duty = dir_up_q ? inc_val : dec_val;
  end

  // ---------------------------------------------------------------------------
  // Counter and duty next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (Tick_in) begin
      cnt_d = wrap ? '0 : (cnt_q + 1'b1);
    end
    // The new duty lands on the same edge the counter returns to 0, so it
    // governs the whole period that starts there. The result never exceeds
    // PERIOD, which fits in CNT_W bits.
    if (apply) begin
      duty_d = CNT_W'(new_duty);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
    end
  end

  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q          <= '0;
      duty_q         <= DUTY_INIT;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      // Compares the pre-edge counter and duty: one cycle of output latency.
      // Duty 0 never matches (always low); duty PERIOD always matches.
      pwm_q          <= (cnt_q < duty_q);
      period_start_q <= wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: direct register outputs or decodes of the state register
  // ---------------------------------------------------------------------------
  assign Req_ack      = (state_q == S_ACK);
  assign Busy         = (state_q != S_IDLE);
  assign Period_start = period_start_q;
  assign Duty_out     = duty_q;
  assign PWM_out      = pwm_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_scheduler
//
// Self-checking bench for pwm_duty_scheduler with default parameters
// (PERIOD 200, STEP 10, DUTY_RST 100). A table of timed vectors covers reset,
// the free-running waveform, a mid-period increment and a cancel; hand-written
// sequences cover saturation, held requests, tick gating and async reset.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_duty_scheduler;

  localparam int CNT_W    = 8;
  localparam int PERIOD   = 200;
  localparam int STEP     = 10;
  localparam int DUTY_RST = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             inc;
  logic             dec;
  logic             ack;
  logic             busy;
  logic             pstart;
  logic [CNT_W-1:0] duty;
  logic             pwm;

  int checks = 0;
  int errors = 0;

  pwm_duty_scheduler #(
    .CNT_W   (CNT_W),
    .PERIOD  (PERIOD),
    .STEP    (STEP),
    .DUTY_RST(DUTY_RST)
  ) dut (
    .Clock_in    (clk),
    .Reset_n     (rst_n),
    .Tick_in     (tick),
    .Inc_req     (inc),
    .Dec_req     (dec),
    .Req_ack     (ack),
    .Busy        (busy),
    .Period_start(pstart),
    .Duty_out    (duty),
    .PWM_out     (pwm)
  );

  always #5 clk = ~clk;

  // One record: inputs to drive, number of edges to run, then expected outputs.
  typedef struct {
    string name;
    logic  tick;
    logic  inc;
    logic  dec;
    int    ncyc;
    int    duty;
    logic  pwm;
    logic  busy;
    logic  ack;
    logic  ps;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic t, logic i, logic d, int n,
                              int du, logic pw, logic bu, logic ak, logic ps);
    vec_t v;
    v.name = name; v.tick = t; v.inc = i; v.dec = d; v.ncyc = n;
    v.duty = du; v.pwm = pw; v.busy = bu; v.ack = ak; v.ps = ps;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full request/ack handshake: raise the lines, wait (bounded) for the ack,
  // check the applied duty and the single-cycle ack, then release.
  task automatic handshake(string name, logic up, logic down, int exp_duty);
    int waited = 0;
    bit seen = 0;
    inc = up;
    dec = down;
    while (!seen && waited < 450) begin
      step(1);
      waited++;
      if (ack === 1'b1) seen = 1;
    end
    check({name, " ack seen"}, 32'(seen), 32'd1);
    check({name, " duty"}, 32'(duty), 32'(exp_duty));
    inc = 1'b0;
    dec = 1'b0;
    step(1);
    check({name, " ack one cycle"}, 32'(ack), 32'd0);
    waited = 0;
    while (busy !== 1'b0 && waited < 10) begin
      step(1);
      waited++;
    end
    check({name, " busy released"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    int lows;
    int ps_cnt;
    int ack_cnt;
    int busy_low;
    int duty_bad;
    int exp_d;

    rst_n = 1'b0;
    tick  = 1'b1;
    inc   = 1'b0;
    dec   = 1'b0;

    // Edge numbers E below count rising edges after reset release.
    // PWM after edge E is ((E-1) mod 200) < duty; Period_start after E=200k.
    vecs.push_back(mk("reset state",      1, 0, 0,   0, 100, 0, 0, 0, 0));
    vecs.push_back(mk("E1 first high",    1, 0, 0,   1, 100, 1, 0, 0, 0));
    vecs.push_back(mk("E100 last high",   1, 0, 0,  99, 100, 1, 0, 0, 0));
    vecs.push_back(mk("E101 first low",   1, 0, 0,   1, 100, 0, 0, 0, 0));
    vecs.push_back(mk("E199 before wrap", 1, 0, 0,  98, 100, 0, 0, 0, 0));
    vecs.push_back(mk("E200 wrap pulse",  1, 0, 0,   1, 100, 0, 0, 0, 1));
    vecs.push_back(mk("E201 new period",  1, 0, 0,   1, 100, 1, 0, 0, 0));
    // Increment latched when cnt=50 (edge 251); wrap edge is 400.
    vecs.push_back(mk("E250 cnt50",       1, 0, 0,  49, 100, 1, 0, 0, 0));
    vecs.push_back(mk("E251 inc latch",   1, 1, 0,   1, 100, 1, 1, 0, 0));
    vecs.push_back(mk("E399 still old",   1, 1, 0, 148, 100, 0, 1, 0, 0));
    vecs.push_back(mk("E400 apply",       1, 1, 0,   1, 110, 0, 1, 1, 1));
    vecs.push_back(mk("E401 ack done",    1, 1, 0,   1, 110, 1, 1, 0, 0));
    vecs.push_back(mk("E402 released",    1, 0, 0,   1, 110, 1, 0, 0, 0));
    vecs.push_back(mk("E510 high 110th",  1, 0, 0, 108, 110, 1, 0, 0, 0));
    vecs.push_back(mk("E511 low",         1, 0, 0,   1, 110, 0, 0, 0, 0));
    // Opposing requests: acked next cycle, no wrap needed, duty unchanged.
    vecs.push_back(mk("E512 cancel ack",  1, 1, 1,   1, 110, 0, 1, 1, 0));
    vecs.push_back(mk("E513 cancel rel",  1, 0, 0,   1, 110, 0, 1, 0, 0));
    vecs.push_back(mk("E514 cancel idle", 1, 0, 0,   1, 110, 0, 0, 0, 0));

    #17;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      tick = vecs[i].tick;
      inc  = vecs[i].inc;
      dec  = vecs[i].dec;
      step(vecs[i].ncyc);
      check({vecs[i].name, " duty"},   32'(duty),   32'(vecs[i].duty));
      check({vecs[i].name, " pwm"},    32'(pwm),    32'(vecs[i].pwm));
      check({vecs[i].name, " busy"},   32'(busy),   32'(vecs[i].busy));
      check({vecs[i].name, " ack"},    32'(ack),    32'(vecs[i].ack));
      check({vecs[i].name, " pstart"}, 32'(pstart), 32'(vecs[i].ps));
    end

    // Edges 515..714 span cnt 114..199,0..113: a full period at duty 110.
    highs = 0;
    ps_cnt = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1);
      if (pwm === 1'b1) highs++;
      if (pstart === 1'b1) ps_cnt++;
    end
    check("period highs at duty 110", 32'(highs), 32'd110);
    check("period starts per period", 32'(ps_cnt), 32'd1);

    // Asynchronous reset while a request is pending.
    inc = 1'b1;
    step(1);
    check("pending before reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset duty", 32'(duty), 32'(DUTY_RST));
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset ack", 32'(ack), 32'd0);
    check("async reset pwm", 32'(pwm), 32'd0);
    check("async reset pstart", 32'(pstart), 32'd0);
    inc = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1);
    ack_cnt = 0;
    busy_low = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      if (ack === 1'b1) ack_cnt++;
      if (busy !== 1'b0) busy_low++;
    end
    check("after reset no stale ack", 32'(ack_cnt), 32'd0);
    check("after reset not busy", 32'(busy_low), 32'd0);
    check("after reset duty", 32'(duty), 32'(DUTY_RST));

    // Saturation upward: 11 increments from 100, last one clamps at 200.
    exp_d = DUTY_RST;
    for (int k = 0; k < 11; k++) begin
      exp_d = (exp_d + STEP > PERIOD) ? PERIOD : exp_d + STEP;
      handshake($sformatf("inc %0d", k), 1'b1, 1'b0, exp_d);
    end
    check("saturated high duty", 32'(duty), 32'(PERIOD));
    lows = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1);
      if (pwm !== 1'b1) lows++;
    end
    check("duty 200 pwm low cycles", 32'(lows), 32'd0);

    // Saturation downward: 21 decrements from 200, last one clamps at 0.
    for (int k = 0; k < 21; k++) begin
      exp_d = (exp_d < STEP) ? 0 : exp_d - STEP;
      handshake($sformatf("dec %0d", k), 1'b0, 1'b1, exp_d);
    end
    check("saturated low duty", 32'(duty), 32'd0);
    highs = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1);
      if (pwm !== 1'b0) highs++;
    end
    check("duty 0 pwm high cycles", 32'(highs), 32'd0);

    // Request held long after its ack: applied once only, Busy stays high.
    inc = 1'b1;
    begin
      int waited = 0;
      while (ack !== 1'b1 && waited < 450) begin
        step(1);
        waited++;
      end
    end
    check("held inc ack", 32'(ack), 32'd1);
    check("held inc duty", 32'(duty), 32'd10);
    ack_cnt = 0;
    busy_low = 0;
    duty_bad = 0;
    for (int k = 0; k < 500; k++) begin
      step(1);
      if (ack === 1'b1) ack_cnt++;
      if (busy !== 1'b1) busy_low++;
      if (duty !== 8'd10) duty_bad++;
    end
    check("held inc extra acks", 32'(ack_cnt), 32'd0);
    check("held inc busy drops", 32'(busy_low), 32'd0);
    check("held inc duty changes", 32'(duty_bad), 32'd0);
    inc = 1'b0;
    step(1);
    check("held inc released busy", 32'(busy), 32'd0);
    // Back in IDLE: an opposing pair is acked on the very next edge.
    inc = 1'b1;
    dec = 1'b1;
    step(1);
    check("idle cancel ack", 32'(ack), 32'd1);
    inc = 1'b0;
    dec = 1'b0;
    step(2);
    check("idle cancel done busy", 32'(busy), 32'd0);

    // Without ticks the counter holds, so a pending change never applies.
    tick = 1'b0;
    dec = 1'b1;
    ack_cnt = 0;
    ps_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      if (ack === 1'b1) ack_cnt++;
      if (pstart === 1'b1) ps_cnt++;
    end
    check("no tick ack", 32'(ack_cnt), 32'd0);
    check("no tick pstart", 32'(ps_cnt), 32'd0);
    check("no tick duty", 32'(duty), 32'd10);
    check("no tick busy", 32'(busy), 32'd1);
    tick = 1'b1;
    handshake("dec after ticks resume", 1'b0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
